// File: rtl/anc_fir_error_pkg.sv
// Shared constants and types for the ANC FIR/error block: data format,
// tap count, controller state encoding and Q(21,20) saturation limits.
package anc_fir_error_pkg;

   localparam int NB_DATA  = 21;
   localparam int NBF_DATA = 20;
   localparam int N_TAPS   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [NB_DATA-1:0] Q_MAX = 21'h0FFFFF;
   localparam logic [NB_DATA-1:0] Q_MIN = 21'h100000;

   // Sign-extend a product into the accumulator width.
   function automatic logic [2*NB_DATA+1:0] ext_prod(input logic [2*NB_DATA-1:0] p);
      return {{2{p[2*NB_DATA-1]}}, p};
   endfunction

endpackage

// File: rtl/anc_fir_error_sattrunc.sv
// SatTruncFP: fixed-point reformat Q(NB_IN,NBF_IN) -> Q(NB_OUT,NBF_OUT),
// flooring dropped fraction bits and clamping to the output range.
module SatTruncFP #(
   parameter int NB_IN   = 44,
   parameter int NBF_IN  = 40,
   parameter int NB_OUT  = 21,
   parameter int NBF_OUT = 20
) (
   input  logic signed [NB_IN-1:0]  i_data,
   output logic signed [NB_OUT-1:0] o_data
);

   localparam int SHIFT   = NBF_IN - NBF_OUT;
   localparam int NB_KEEP = NB_IN - SHIFT;

   logic [NB_KEEP-1:0] trunc;
   logic               ovf_pos;
   logic               ovf_neg;

   // Dropping LSBs of a two's complement value is a floor.
   assign trunc = i_data[NB_IN-1:SHIFT];

   generate
      if (SHIFT > 0) begin : g_lsb
         logic unused_lsb;
         assign unused_lsb = ^i_data[SHIFT-1:0];
      end
   endgenerate

   // Overflow when the bits above the output sign are not a sign extension.
   always_comb begin
      ovf_pos = 1'b0;
      ovf_neg = 1'b0;
      if (trunc[NB_KEEP-1] == 1'b0) begin
         ovf_pos = |trunc[NB_KEEP-2:NB_OUT-1];
      end else begin
         ovf_neg = ~&trunc[NB_KEEP-2:NB_OUT-1];
      end
   end

   // Select clamp limit or the in-range truncated value.
   always_comb begin
      o_data = trunc[NB_OUT-1:0];
      if (ovf_pos) begin
         o_data = {1'b0, {(NB_OUT-1){1'b1}}};
      end else if (ovf_neg) begin
         o_data = {1'b1, {(NB_OUT-1){1'b0}}};
      end else begin
         o_data = trunc[NB_OUT-1:0];
      end
   end

endmodule

// File: rtl/anc_fir_error.sv
// ANC 4-tap FIR with error output: one time-shared multiplier walks the
// taps after each accepted sample, then y and e = d - y are saturated.
module anc_fir_error #(
   parameter int NB_DATA  = anc_fir_error_pkg::NB_DATA,
   parameter int NBF_DATA = anc_fir_error_pkg::NBF_DATA
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_valid,
   input  logic signed [NB_DATA-1:0] i_mic1,
   input  logic signed [NB_DATA-1:0] i_mic2,
   input  logic signed [NB_DATA-1:0] i_filter_coeff0,
   input  logic signed [NB_DATA-1:0] i_filter_coeff1,
   input  logic signed [NB_DATA-1:0] i_filter_coeff2,
   input  logic signed [NB_DATA-1:0] i_filter_coeff3,
   output logic signed [NB_DATA-1:0] o_mic1_reg0,
   output logic signed [NB_DATA-1:0] o_mic1_reg1,
   output logic signed [NB_DATA-1:0] o_mic1_reg2,
   output logic signed [NB_DATA-1:0] o_mic1_reg3,
   output logic signed [NB_DATA-1:0] o_y,
   output logic signed [NB_DATA-1:0] o_error,
   output logic                      o_valid,
   output logic                      o_busy
);

   import anc_fir_error_pkg::*;

   localparam int NB_PROD = 2 * NB_DATA;
   localparam int NB_ACC  = NB_PROD + 2;
   localparam int NBF_ACC = 2 * NBF_DATA;
   localparam int NB_IDX  = $clog2(N_TAPS);

   state_t state;
   state_t state_next;

   logic signed [NB_DATA-1:0] dline  [N_TAPS];
   logic signed [NB_DATA-1:0] h_snap [N_TAPS];
   logic signed [NB_DATA-1:0] coeff  [N_TAPS];
   logic signed [NB_DATA-1:0] d_lat;
   logic signed [NB_ACC-1:0]  acc;
   logic        [NB_IDX-1:0]  idx;

   logic signed [NB_PROD-1:0] prod;
   logic signed [NB_DATA-1:0] y_sat;
   logic signed [NB_DATA:0]   err_wide;
   logic signed [NB_DATA-1:0] err_sat;

   logic accept;
   logic mac_en;
   logic done_en;
   logic last_tap;

   assign coeff[0] = i_filter_coeff0;
   assign coeff[1] = i_filter_coeff1;
   assign coeff[2] = i_filter_coeff2;
   assign coeff[3] = i_filter_coeff3;

   assign o_mic1_reg0 = dline[0];
   assign o_mic1_reg1 = dline[1];
   assign o_mic1_reg2 = dline[2];
   assign o_mic1_reg3 = dline[3];

   assign last_tap = (idx == NB_IDX'(N_TAPS - 1));

   // The single multiplier: operands selected by the current tap index.
   assign prod = h_snap[idx] * dline[idx];

   // Error is formed one bit wider so d - y cannot wrap before clamping.
   assign err_wide = {d_lat[NB_DATA-1], d_lat} - {y_sat[NB_DATA-1], y_sat};

   SatTruncFP #(
      .NB_IN   (NB_ACC),
      .NBF_IN  (NBF_ACC),
      .NB_OUT  (NB_DATA),
      .NBF_OUT (NBF_DATA)
   ) u_sat_y (
      .i_data (acc),
      .o_data (y_sat)
   );

   SatTruncFP #(
      .NB_IN   (NB_DATA + 1),
      .NBF_IN  (NBF_DATA),
      .NB_OUT  (NB_DATA),
      .NBF_OUT (NBF_DATA)
   ) u_sat_err (
      .i_data (err_wide),
      .o_data (err_sat)
   );

   // Controller state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Controller next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (i_valid) begin
               state_next = ST_MAC;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_MAC: begin
            if (last_tap) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_MAC;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Controller output decode.
   always_comb begin
      accept  = 1'b0;
      mac_en  = 1'b0;
      done_en = 1'b0;
      o_busy  = 1'b1;
      case (state)
         ST_IDLE: begin
            accept = i_valid;
            o_busy = 1'b0;
         end
         ST_MAC:  mac_en  = 1'b1;
         ST_DONE: done_en = 1'b1;
         default: o_busy  = 1'b0;
      endcase
   end

   // Datapath: delay line, snapshots, accumulation and result registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < N_TAPS; k++) begin
            dline[k]  <= '0;
            h_snap[k] <= '0;
         end
         d_lat   <= '0;
         acc     <= '0;
         idx     <= '0;
         o_y     <= '0;
         o_error <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (accept) begin
            for (int k = N_TAPS - 1; k > 0; k--) begin
               dline[k] <= dline[k-1];
            end
            dline[0] <= i_mic1;
            for (int k = 0; k < N_TAPS; k++) begin
               h_snap[k] <= coeff[k];
            end
            d_lat <= i_mic2;
            acc   <= '0;
            idx   <= '0;
         end else if (mac_en) begin
            acc <= acc + $signed(ext_prod(prod));
            idx <= idx + NB_IDX'(1);
         end else if (done_en) begin
            o_y     <= y_sat;
            o_error <= err_sat;
            o_valid <= 1'b1;
         end else begin
            acc <= acc;
         end
      end
   end

endmodule

// File: tb/tb_anc_fir_error.sv
// Self-checking bench for anc_fir_error: constant vector table, hand-written
// timing/reset sequences, and randomized traffic against an arithmetic model.
module tb_anc_fir_error;

   import anc_fir_error_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [20:0] mic1 = '0, mic2 = '0;
   logic [20:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0;
   logic [20:0] r0, r1, r2, r3, y, err;
   logic        ovalid, busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   anc_fir_error dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid),
      .i_mic1(mic1), .i_mic2(mic2),
      .i_filter_coeff0(c0), .i_filter_coeff1(c1),
      .i_filter_coeff2(c2), .i_filter_coeff3(c3),
      .o_mic1_reg0(r0), .o_mic1_reg1(r1), .o_mic1_reg2(r2), .o_mic1_reg3(r3),
      .o_y(y), .o_error(err), .o_valid(ovalid), .o_busy(busy)
   );

   typedef struct {
      string           name;
      logic [3:0][20:0] xs;   // xs[0] fed first
      logic [3:0][20:0] h;
      logic [20:0]     d;
      logic [20:0]     ey;
      logic [20:0]     ee;
   } vec_t;

   vec_t tbl[6];

   // Reference model: newest sample at hist[0].
   logic [20:0] hist[4];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic longint clamp21(input longint v);
      if (v > 64'sd1048575) return 64'sd1048575;
      else if (v < -64'sd1048576) return -64'sd1048576;
      else return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) hist[k] = 21'h0;
   endtask

   task automatic model_step(input logic [20:0] x, input logic [20:0] d,
                             input logic [3:0][20:0] h,
                             output logic [20:0] ey, output logic [20:0] ee);
      longint s;
      longint yv;
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      s = 0;
      for (int k = 0; k < 4; k++)
         s += longint'($signed(h[k])) * longint'($signed(hist[k]));
      yv = clamp21(s >>> 20);
      ey = yv[20:0];
      s = clamp21(longint'($signed(d)) - yv);
      ee = s[20:0];
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   function automatic logic [20:0] rnd21();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 1) == 0) return {{4{r[16]}}, r[16:0]};
      else return r[20:0];
   endfunction

   // Present one sample while idle; wait (bounded) for its result.
   task automatic run_sample(input logic [20:0] x, input logic [20:0] d,
                             input logic [3:0][20:0] h, input bit noisy,
                             output logic [20:0] gy, output logic [20:0] ge,
                             output int lat);
      mic1 = x; mic2 = d;
      c0 = h[0]; c1 = h[1]; c2 = h[2]; c3 = h[3];
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      lat = 99; gy = 'x; ge = 'x;
      for (int t = 1; t <= 20; t++) begin
         if (noisy) begin
            valid = 1'($urandom_range(0, 1));
            mic1 = rnd21(); mic2 = rnd21();
            c0 = rnd21(); c1 = rnd21(); c2 = rnd21(); c3 = rnd21();
         end
         @(posedge clk); #1;
         if (ovalid) begin
            lat = t; gy = y; ge = err;
            break;
         end
      end
      valid = 1'b0;
   endtask

   initial begin
      logic [20:0] gy, ge, ey, ee;
      logic [3:0][20:0] h;
      int lat, nbusy, nvalid;

      tbl[0] = '{"impulse", {21'h0, 21'h0, 21'h0, 21'h080000} , {21'h0, 21'h0, 21'h0, 21'h080000},
                 21'h0, 21'h040000, 21'h1C0000};
      // xs packed as {xs[3],xs[2],xs[1],xs[0]}; h as {h3,h2,h1,h0}
      tbl[0].xs = {21'h080000, 21'h0, 21'h0, 21'h0};
      tbl[1] = '{"delay", {21'h0, 21'h0, 21'h0, 21'h080000}, {21'h080000, 21'h0, 21'h0, 21'h0},
                 21'h0, 21'h040000, 21'h1C0000};
      tbl[2] = '{"sat_pos", {4{21'h100000}}, {4{21'h100000}}, 21'h100000, Q_MAX, Q_MIN};
      tbl[3] = '{"sat_neg", {4{21'h100000}}, {4{21'h0FFFFF}}, 21'h0FFFFF, Q_MIN, Q_MAX};
      tbl[4] = '{"floor", {21'h000001, 21'h0, 21'h0, 21'h0}, {21'h0, 21'h0, 21'h0, 21'h1FFFFF},
                 21'h0, 21'h1FFFFF, 21'h000001};
      tbl[5] = '{"mixed", {21'h080000, 21'h0, 21'h020000, 21'h040000},
                 {21'h080000, 21'h1C0000, 21'h0, 21'h080000},
                 21'h020000, 21'h058000, 21'h1C8000};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_y", y, 0); check("rst_err", err, 0);
      check("rst_valid", ovalid, 0); check("rst_busy", busy, 0);
      check("rst_reg0", r0, 0); check("rst_reg3", r3, 0);
      rst = 1'b0;

      // Vector table: reset, feed four samples, check the fourth result
      for (int i = 0; i < 6; i++) begin
         do_reset();
         for (int k = 0; k < 4; k++)
            run_sample(tbl[i].xs[k], tbl[i].d, tbl[i].h, 1'b0, gy, ge, lat);
         check({tbl[i].name, "_y"}, gy, tbl[i].ey);
         check({tbl[i].name, "_err"}, ge, tbl[i].ee);
         check({tbl[i].name, "_lat"}, lat, 5);
         check({tbl[i].name, "_reg3"}, r3, tbl[i].xs[0]);
         check({tbl[i].name, "_hold_y"}, y, tbl[i].ey);
      end

      // Busy: i_valid held high, one accept every 6 cycles
      do_reset();
      nbusy = 0; nvalid = 0;
      for (int n = 0; n < 36; n++) begin
         mic1 = 21'(100 + n);
         valid = 1'b1;
         @(posedge clk); #1;
         if (busy) nbusy++;
         if (ovalid) nvalid++;
      end
      valid = 1'b0;
      check("busy_cycles", nbusy, 30);
      check("busy_pulses", nvalid, 6);
      check("busy_reg0", r0, 21'd130);
      check("busy_reg1", r1, 21'd124);
      check("busy_reg3", r3, 21'd112);

      // Coefficient snapshot: h0 cleared one cycle after accept
      do_reset();
      mic1 = 21'h080000; mic2 = 21'h0; c0 = 21'h080000; c1 = '0; c2 = '0; c3 = '0;
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
      c0 = 21'h0;
      lat = 99;
      for (int t = 2; t <= 20; t++) begin
         @(posedge clk); #1;
         if (ovalid) begin lat = t; break; end
      end
      check("snap_lat", lat, 5);
      check("snap_y", y, 21'h040000);

      // Reset during MAC cycle 2
      h = {21'h0, 21'h0, 21'h0, 21'h080000};
      run_sample(21'h080000, 21'h0, h, 1'b0, gy, ge, lat);
      mic1 = 21'h0C0000; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid_rst_y", y, 0); check("mid_rst_err", err, 0);
      check("mid_rst_busy", busy, 0); check("mid_rst_reg0", r0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      nvalid = 0;
      for (int t = 0; t < 8; t++) begin
         @(posedge clk); #1;
         if (ovalid) nvalid++;
      end
      check("mid_rst_novalid", nvalid, 0);
      run_sample(21'h080000, 21'h0, h, 1'b0, gy, ge, lat);
      check("post_rst_y", gy, 21'h040000);
      check("post_rst_err", ge, 21'h1C0000);
      check("post_rst_lat", lat, 5);
      check("post_rst_reg1", r1, 0);

      // Randomized traffic against the model
      do_reset();
      model_reset();
      for (int n = 0; n < 80; n++) begin
         logic [20:0] x, d;
         bit noisy;
         x = rnd21(); d = rnd21();
         h = {rnd21(), rnd21(), rnd21(), rnd21()};
         noisy = 1'($urandom_range(0, 1));
         run_sample(x, d, h, noisy, gy, ge, lat);
         model_step(x, d, h, ey, ee);
         check("rnd_y", gy, ey);
         check("rnd_err", ge, ee);
         check("rnd_lat", lat, 5);
         check("rnd_reg0", r0, x);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/anc_fir_error.md
ANC_FIR_ERROR -- requirements
Module: anc_fir_error

Interface
REQ-001 SHALL have parameter NB_DATA, 21, total sample/coefficient width (signed).
REQ-002 SHALL have parameter NBF_DATA, 20, fractional bits; sample format Q(21,20).
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  new sample pair strobe.
REQ-006 SHALL have port i_mic1  input  NB_DATA  reference-mic sample x[n], signed.
REQ-007 SHALL have port i_mic2  input  NB_DATA  error-mic (desired) sample d[n], signed.
REQ-008 SHALL have ports i_filter_coeff0..3  input  NB_DATA each  adaptive taps h0..h3 from the LMS updater.
REQ-009 SHALL have ports o_mic1_reg0..3  output  NB_DATA each  delay line, reg0 = x[n], reg3 = x[n-3].
REQ-010 SHALL have port o_y  output  NB_DATA  filter output y[n].
REQ-011 SHALL have port o_error  output  NB_DATA  e[n] = d[n] - y[n].
REQ-012 SHALL have port o_valid  output  1  one-cycle pulse, o_y/o_error updated.
REQ-013 SHALL have port o_busy  output  1  high whenever state != IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> MAC -> DONE -> IDLE.
REQ-015 Accept SHALL occur on an edge with i_valid=1 and state=IDLE: shift delay line (reg3<=reg2, reg2<=reg1, reg1<=reg0, reg0<=i_mic1), latch i_mic2, snapshot h0..h3, clear accumulator, tap index<=0, state<=MAC.
REQ-016 i_valid with state != IDLE SHALL be ignored (no shift, no latch, no error flag).
REQ-017 MAC SHALL last exactly 4 cycles, one tap per cycle, acc += h_snap[k]*reg[k], k=0..3; after k=3, state<=DONE.
REQ-018 Products SHALL be full precision Q(42,40); accumulator Q(44,40), no intermediate overflow possible.
REQ-019 In DONE, o_y SHALL be acc saturated/truncated to Q(21,20): floor of dropped LSBs, clamp to 21'h0FFFFF / 21'h100000.
REQ-020 In DONE, o_error SHALL be (d latched - o_y value) computed at Q(22,20), then saturated to Q(21,20); o_valid<=1 for one cycle; state<=IDLE.
REQ-021 Latency: o_valid SHALL be high in the cycle following the 5th edge after the accepting edge; next accept possible on the 6th edge; max throughput 1 sample / 6 cycles.
REQ-022 Coefficient changes after the accepting edge SHALL NOT affect the current result.
REQ-023 o_mic1_reg0..3, o_y, o_error SHALL hold their values between updates.

Reset
REQ-024 Asserting i_rst SHALL immediately (asynchronously) clear delay line, snapshots, accumulator, o_y, o_error, o_valid, index to 0 and state to IDLE; o_busy=0.
REQ-025 Reset mid-MAC SHALL abort the computation with no o_valid pulse; first accept allowed on the first edge after i_rst deasserts.

Structure
REQ-026 Shared package SHALL hold NB_DATA, NBF_DATA, N_TAPS=4, FSM state encodings, Q(21,20) max/min constants.
REQ-027 Saturating truncation SHALL reuse the existing SatTruncFP sub-module (instances: y from (44,40), error from (22,20)).
REQ-028 Single multiplier, time-shared across taps.

Verification
REQ-029 Impulse: reset, h0=21'h080000 (0.5), others 0, x=21'h080000, d=0 -> o_y=21'h040000, o_error=21'h1C0000, o_valid 5 edges after accept.
REQ-030 Delay: feed x=0.5 then three zeros with h3=0.5 only -> 4th result o_y=21'h040000, o_mic1_reg3=21'h080000.
REQ-031 Saturation: all x=21'h100000, all h=21'h100000, d=21'h100000 -> o_y=21'h0FFFFF, o_error=21'h100000.
REQ-032 Busy: i_valid held high continuously -> exactly one accept per 6 cycles, o_busy high 5 cycles of each 6.
REQ-033 Coefficient snapshot: change h0 to 0 one cycle after accept -> result uses old h0.
REQ-034 Reset mid-operation: assert i_rst during MAC cycle 2 -> no o_valid, all outputs 0 immediately, clean result on next sample.
